// File: rtl/seq_detector_pkg.sv
// Shared helpers for seq_detector_n: state-width sizing and the
// prefix/suffix search that builds the KMP-style transition table.
package seq_detector_pkg;

  // Longest pattern the search helpers are written to handle.
  localparam int MAX_WIDTH = 16;

  // Bits needed to hold a matched-prefix length 0..width.
  function automatic int state_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Longest prefix of the pattern (length <= cap) that is a suffix of the
  // string formed by the first k pattern bits followed by bit b.
  // The pattern is read MSB first: bit i of the sequence is pattern[width-1-i].
  function automatic int border(input logic [MAX_WIDTH-1:0] pattern,
                                input int width, input int k,
                                input logic b, input int cap);
    int   n;
    int   best;
    int   idx;
    logic ok;
    logic sbit;
    n    = k + 1;
    best = 0;
    for (int l = 1; l <= MAX_WIDTH; l++) begin
      if (l <= n && l <= cap) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_WIDTH; j++) begin
          if (j < l) begin
            idx  = n - l + j;
            sbit = (idx == k) ? b : pattern[width-1-idx];
            if (sbit != pattern[width-1-j]) ok = 1'b0;
          end
        end
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  // Next matched-prefix length after accepting bit b in state k.
  // Returns width when the bit completes the pattern.
  function automatic int next_len(input logic [MAX_WIDTH-1:0] pattern,
                                  input int width, input int k,
                                  input logic b);
    return border(pattern, width, k, b, width);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-high reset.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count increments, holding at all-ones; clear beats increment.
  // NOTE: every register here and in the detector gets an explicit reset
  // value because the outputs must read 0 immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_detector_n.sv
// Parametrised Moore sequence detector for a qualified serial bit stream.
// State is the matched-prefix length; transitions come from a table built
// at elaboration. Supports overlap, lock-on-match and a saturating counter.
module seq_detector_n
  import seq_detector_pkg::*;
#(
  parameter int                       PATTERN_WIDTH = 4,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 4'b0110,
  parameter bit                       OVERLAP       = 1'b1,
  parameter bit                       LOCK_ON_MATCH = 1'b0,
  parameter int                       COUNT_WIDTH   = 8
) (
  input  logic                                 CLOCK,
  input  logic                                 RESET,
  input  logic                                 X,
  input  logic                                 VALID,
  input  logic                                 CLEAR,
  output logic                                 Z,
  output logic                                 LOCKED,
  output logic [COUNT_WIDTH-1:0]               MATCH_COUNT,
  output logic [$clog2(PATTERN_WIDTH+1)-1:0]   CurrentState
);

  localparam int SW = state_width(PATTERN_WIDTH);
  localparam logic [MAX_WIDTH-1:0] PAT_EXT = MAX_WIDTH'(PATTERN);

  // Last real state before a match, and where a match sends us.
  localparam logic [SW-1:0] LAST_STATE = SW'(PATTERN_WIDTH - 1);
  localparam logic [SW-1:0] MATCH_NEXT =
    OVERLAP ? SW'(border(PAT_EXT, PATTERN_WIDTH, PATTERN_WIDTH - 1,
                         PATTERN[0], PATTERN_WIDTH - 1))
            : '0;

  logic [SW-1:0] next_on0 [PATTERN_WIDTH];
  logic [SW-1:0] next_on1 [PATTERN_WIDTH];
  logic [SW-1:0] next_state;
  logic          accept;
  logic          hit;
  logic          count_inc;

  // Constant transition table: one entry per state and input bit.
  for (genvar k = 0; k < PATTERN_WIDTH; k++) begin : g_tab
    assign next_on0[k] = SW'(next_len(PAT_EXT, PATTERN_WIDTH, k, 1'b0));
    assign next_on1[k] = SW'(next_len(PAT_EXT, PATTERN_WIDTH, k, 1'b1));
  end

  // Select the table entry for the current state and detect a completed match.
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    next_state = '0;
    accept     = VALID && !LOCKED;
    hit        = (CurrentState == LAST_STATE) && (X == PATTERN[0]);
    count_inc  = accept && hit && !CLEAR;
    for (int k = 0; k < PATTERN_WIDTH; k++) begin
      if (CurrentState == SW'(k)) next_state = X ? next_on1[k] : next_on0[k];
    end
  end

  // State, match pulse and lock flag; priority RESET > CLEAR > VALID.
  // NOTE: non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      CurrentState <= '0;
      Z            <= 1'b0;
      LOCKED       <= 1'b0;
    end else if (CLEAR) begin
      CurrentState <= '0;
      Z            <= 1'b0;
      LOCKED       <= 1'b0;
    end else begin
      Z <= 1'b0;
      if (accept) begin
        if (hit) begin
          Z            <= 1'b1;
          CurrentState <= MATCH_NEXT;
          if (LOCK_ON_MATCH) LOCKED <= 1'b1;
        end else begin
          CurrentState <= next_state;
        end
      end
    end
  end

  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_count (
    .clk   (CLOCK),
    .rst   (RESET),
    .inc   (count_inc),
    .clr   (CLEAR),
    .count (MATCH_COUNT)
  );

endmodule

// File: tb/tb_seq_detector_n.sv
// Directed bench for seq_detector_n: five parameter sets share one stimulus
// bus; each vector names the instance whose outputs it checks.
module tb_seq_detector_n;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic X     = 1'b0;
  logic VALID = 1'b0;
  logic CLEAR = 1'b0;

  // d0: defaults (0110). d1: 1010 overlap. d2: 1010 no overlap.
  // d3: 0110 lock-on-match. d4: 11, overlap, 2-bit counter.
  logic       z0, z1, z2, z3, z4;
  logic       l0, l1, l2, l3, l4;
  logic [7:0] c0, c1, c2, c3;
  logic [1:0] c4;
  logic [2:0] s0, s1, s2, s3;
  logic [1:0] s4;

  seq_detector_n u_d0 (
    .CLOCK(CLOCK), .RESET(RESET), .X(X), .VALID(VALID), .CLEAR(CLEAR),
    .Z(z0), .LOCKED(l0), .MATCH_COUNT(c0), .CurrentState(s0));

  seq_detector_n #(.PATTERN_WIDTH(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) u_d1 (
    .CLOCK(CLOCK), .RESET(RESET), .X(X), .VALID(VALID), .CLEAR(CLEAR),
    .Z(z1), .LOCKED(l1), .MATCH_COUNT(c1), .CurrentState(s1));

  seq_detector_n #(.PATTERN_WIDTH(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) u_d2 (
    .CLOCK(CLOCK), .RESET(RESET), .X(X), .VALID(VALID), .CLEAR(CLEAR),
    .Z(z2), .LOCKED(l2), .MATCH_COUNT(c2), .CurrentState(s2));

  seq_detector_n #(.LOCK_ON_MATCH(1'b1)) u_d3 (
    .CLOCK(CLOCK), .RESET(RESET), .X(X), .VALID(VALID), .CLEAR(CLEAR),
    .Z(z3), .LOCKED(l3), .MATCH_COUNT(c3), .CurrentState(s3));

  seq_detector_n #(.PATTERN_WIDTH(2), .PATTERN(2'b11), .OVERLAP(1'b1),
                   .COUNT_WIDTH(2)) u_d4 (
    .CLOCK(CLOCK), .RESET(RESET), .X(X), .VALID(VALID), .CLEAR(CLEAR),
    .Z(z4), .LOCKED(l4), .MATCH_COUNT(c4), .CurrentState(s4));

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int         dut;
    bit         rst_before;
    logic       x;
    logic       valid;
    logic       clear;
    logic       z;
    logic       locked;
    logic [7:0] cnt;
    logic [4:0] st;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function void add(input int d, input bit r, input logic x, input logic v,
                    input logic c, input logic z, input logic l,
                    input logic [7:0] cnt, input logic [4:0] st);
    vec_t t;
    t.dut = d; t.rst_before = r; t.x = x; t.valid = v; t.clear = c;
    t.z = z; t.locked = l; t.cnt = cnt; t.st = st;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic get(input int d, output logic z, output logic l,
                     output logic [7:0] c, output logic [4:0] s);
    case (d)
      0:       begin z = z0; l = l0; c = c0;       s = 5'(s0); end
      1:       begin z = z1; l = l1; c = c1;       s = 5'(s1); end
      2:       begin z = z2; l = l2; c = c2;       s = 5'(s2); end
      3:       begin z = z3; l = l3; c = c3;       s = 5'(s3); end
      default: begin z = z4; l = l4; c = 8'(c4);   s = 5'(s4); end
    endcase
  endtask

  task automatic check_all(input string tag, input int d, input logic ez,
                           input logic el, input logic [7:0] ec,
                           input logic [4:0] es);
    logic z, l;
    logic [7:0] c;
    logic [4:0] s;
    get(d, z, l, c, s);
    check($sformatf("%s d%0d Z", tag, d), 32'(z), 32'(ez));
    check($sformatf("%s d%0d LOCKED", tag, d), 32'(l), 32'(el));
    check($sformatf("%s d%0d MATCH_COUNT", tag, d), 32'(c), 32'(ec));
    check($sformatf("%s d%0d CurrentState", tag, d), 32'(s), 32'(es));
  endtask

  // Pulse reset mid-cycle and confirm every output of instance d is 0.
  task automatic do_reset(input int d);
    RESET = 1'b1;
    #1;
    check_all("reset", d, 1'b0, 1'b0, 8'd0, 5'd0);
    #1;
    RESET = 1'b0;
  endtask

  // Drive one vector, take one edge, compare just after it.
  task automatic step(input vec_t t, input string tag);
    X = t.x; VALID = t.valid; CLEAR = t.clear;
    @(posedge CLOCK);
    #1;
    check_all(tag, t.dut, t.z, t.locked, t.cnt, t.st);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t h;

    // d0: basic 0110 match, failure back to state 1.
    add(0,1, 0,1,0, 0,0,8'd0,5'd1);
    add(0,0, 1,1,0, 0,0,8'd0,5'd2);
    add(0,0, 1,1,0, 0,0,8'd0,5'd3);
    add(0,0, 0,1,0, 1,0,8'd1,5'd1);
    add(0,0, 1,0,0, 0,0,8'd1,5'd1);
    // d0: VALID gaps between bits.
    add(0,0, 0,1,0, 0,0,8'd1,5'd1);
    add(0,0, 1,0,0, 0,0,8'd1,5'd1);
    add(0,0, 1,0,0, 0,0,8'd1,5'd1);
    add(0,0, 1,1,0, 0,0,8'd1,5'd2);
    add(0,0, 1,1,0, 0,0,8'd1,5'd3);
    add(0,0, 0,0,0, 0,0,8'd1,5'd3);
    add(0,0, 0,1,0, 1,0,8'd2,5'd1);
    add(0,0, 0,0,0, 0,0,8'd2,5'd1);
    // d0: CLEAR with a would-be matching bit discards it.
    add(0,0, 0,1,0, 0,0,8'd2,5'd1);
    add(0,0, 1,1,0, 0,0,8'd2,5'd2);
    add(0,0, 1,1,0, 0,0,8'd2,5'd3);
    add(0,0, 0,1,1, 0,0,8'd0,5'd0);
    add(0,0, 0,1,0, 0,0,8'd0,5'd1);
    // d1: 1010 with overlap -> two pulses.
    add(1,1, 1,1,0, 0,0,8'd0,5'd1);
    add(1,0, 0,1,0, 0,0,8'd0,5'd2);
    add(1,0, 1,1,0, 0,0,8'd0,5'd3);
    add(1,0, 0,1,0, 1,0,8'd1,5'd2);
    add(1,0, 1,1,0, 0,0,8'd1,5'd3);
    add(1,0, 0,1,0, 1,0,8'd2,5'd2);
    add(1,0, 0,0,0, 0,0,8'd2,5'd2);
    // d2: 1010 without overlap -> one pulse.
    add(2,1, 1,1,0, 0,0,8'd0,5'd1);
    add(2,0, 0,1,0, 0,0,8'd0,5'd2);
    add(2,0, 1,1,0, 0,0,8'd0,5'd3);
    add(2,0, 0,1,0, 1,0,8'd1,5'd0);
    add(2,0, 1,1,0, 0,0,8'd1,5'd1);
    add(2,0, 0,1,0, 0,0,8'd1,5'd2);
    // d3: lock on first match, ignore further input, clear, match again.
    add(3,1, 0,1,0, 0,0,8'd0,5'd1);
    add(3,0, 1,1,0, 0,0,8'd0,5'd2);
    add(3,0, 1,1,0, 0,0,8'd0,5'd3);
    add(3,0, 0,1,0, 1,1,8'd1,5'd1);
    add(3,0, 0,1,0, 0,1,8'd1,5'd1);
    add(3,0, 1,1,0, 0,1,8'd1,5'd1);
    add(3,0, 1,1,0, 0,1,8'd1,5'd1);
    add(3,0, 0,1,0, 0,1,8'd1,5'd1);
    add(3,0, 0,1,1, 0,0,8'd0,5'd0);
    add(3,0, 0,1,0, 0,0,8'd0,5'd1);
    add(3,0, 1,1,0, 0,0,8'd0,5'd2);
    add(3,0, 1,1,0, 0,0,8'd0,5'd3);
    add(3,0, 0,1,0, 1,1,8'd1,5'd1);
    // d4: run of ones on pattern 11 -> back-to-back pulses, count saturates.
    add(4,1, 1,1,0, 0,0,8'd0,5'd1);
    add(4,0, 1,1,0, 1,0,8'd1,5'd1);
    add(4,0, 1,1,0, 1,0,8'd2,5'd1);
    add(4,0, 1,1,0, 1,0,8'd3,5'd1);
    add(4,0, 1,1,0, 1,0,8'd3,5'd1);
    add(4,0, 1,1,0, 1,0,8'd3,5'd1);
    add(4,0, 1,0,0, 0,0,8'd3,5'd1);

    @(negedge CLOCK);
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset(vecs[i].dut);
      step(vecs[i], $sformatf("v%0d", i));
    end

    // Asynchronous reset mid-sequence on d0: first build up a count.
    do_reset(0);
    h.dut = 0; h.rst_before = 0; h.clear = 0; h.valid = 1; h.locked = 0;
    h.x = 0; h.z = 0; h.cnt = 8'd0; h.st = 5'd1; step(h, "ar0");
    h.x = 1; h.st = 5'd2;                      step(h, "ar1");
    h.x = 1; h.st = 5'd3;                      step(h, "ar2");
    h.x = 0; h.z = 1; h.cnt = 8'd1; h.st = 5'd1; step(h, "ar3");
    h.x = 0; h.z = 0; h.st = 5'd1;             step(h, "ar4");
    h.x = 1; h.st = 5'd2;                      step(h, "ar5");
    h.x = 1; h.st = 5'd3;                      step(h, "ar6");
    // Reset between edges: outputs must drop without a clock edge.
    #2;
    RESET = 1'b1;
    #1;
    check_all("async", 0, 1'b0, 1'b0, 8'd0, 5'd0);
    RESET = 1'b0;
    // The pending 0 must not complete a match; a fresh 0110 must.
    h.x = 0; h.z = 0; h.cnt = 8'd0; h.st = 5'd1; step(h, "ar7");
    h.x = 0; h.st = 5'd1;                      step(h, "ar8");
    h.x = 1; h.st = 5'd2;                      step(h, "ar9");
    h.x = 1; h.st = 5'd3;                      step(h, "ar10");
    h.x = 0; h.z = 1; h.cnt = 8'd1; h.st = 5'd1; step(h, "ar11");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_n.md
# seq_detector_n

Parametrised Moore sequence detector: the next generation of the team's single-bit serial-input FSMs. It watches a qualified serial bit stream X and asserts Z for one cycle after the last PATTERN_WIDTH accepted bits equal PATTERN. It adds overlap/non-overlap mode, an optional lock-on-match (absorbing) mode, a saturating match counter and a synchronous clear. All combinational logic is fully assigned on every path, so the block contains no latches. It sits between a serial front end and a control FSM that consumes Z/LOCKED.

## Interface
- PATTERN_WIDTH, 4: pattern length W, range 2..16.
- PATTERN, 4'b0110: target sequence, compared MSB first (PATTERN[W-1] is the first bit received).
- OVERLAP, 1: 1 = a match's trailing bits may start the next match; 0 = history is discarded after each match.
- LOCK_ON_MATCH, 0: 1 = after the first match, hold LOCKED and ignore X until CLEAR.
- COUNT_WIDTH, 8: width of MATCH_COUNT.
- CLOCK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- X  input  1  serial data bit.
- VALID  input  1  X is accepted only on edges where VALID=1.
- CLEAR  input  1  synchronous clear of the match state, MATCH_COUNT and LOCKED.
- Z  output  1  registered match pulse.
- LOCKED  output  1  lock status (always 0 when LOCK_ON_MATCH=0).
- MATCH_COUNT  output  COUNT_WIDTH  number of matches, saturating.
- CurrentState  output  $clog2(W+1)  current matched-prefix length k (debug).

## Operation
- State k (0..W-1) is the length of the longest pattern prefix that is a suffix of the accepted history.
- Accepted bit b at state k:
  - If b == PATTERN[W-1-k], go to k+1.
  - Otherwise go to the longest proper prefix that is a suffix of (prefix_k, b). This is the KMP failure transition, computed at elaboration.
- Reaching k+1 == W is a match:
  - Z=1 next cycle.
  - MATCH_COUNT increments unless it equals 2^COUNT_WIDTH-1, where it holds.
  - Next state: failure state of the full pattern if OVERLAP=1, else 0.
  - If LOCK_ON_MATCH=1: LOCKED<=1; state is held and further X is ignored (absorbing), Z stays 0 after its single pulse.
- VALID=0: state, Z(<=0) and count unchanged apart from Z returning low.
- CLEAR=1: state<=0, Z<=0, MATCH_COUNT<=0, LOCKED<=0. CLEAR wins over a simultaneous VALID; that bit is discarded, not counted.
- RESET: all outputs and the state go to 0 immediately. Reset mid-sequence discards the partial prefix.

## Timing
- Z, LOCKED, MATCH_COUNT and CurrentState are all registered. Their reset values are all 0.
- Latency: the final pattern bit is sampled at edge n. Z=1, LOCKED (if enabled) and the updated MATCH_COUNT are visible from edge n until edge n+1.
- Z is a single-cycle pulse. Back-to-back matches (OVERLAP=1 with a periodic pattern, e.g. 11 on a run of 1s) give Z high on consecutive cycles, and each cycle counts.
- Next-state and output logic is combinational with default assignments at the top of every block. No incomplete case or if statements.

## Structure
- Package seq_detector_pkg holds:
  - function next_len(pattern, width, k, b), used to build the transition table at elaboration.
  - the clog2-based state-width constant.
- Sub-module sat_counter (parameter WIDTH; inputs inc, clr; output count) provides MATCH_COUNT.
- The top level holds the state register, the transition logic, Z/LOCKED registers and the CLEAR/RESET priority (RESET > CLEAR > VALID).

## Test plan
- Default params, VALID=1, X=0,1,1,0 -> Z=1 exactly one cycle after the 4th bit; MATCH_COUNT=1; CurrentState returns to 1 (failure of 0110).
- PATTERN=4'b1010, OVERLAP=1, X=1,0,1,0,1,0 -> Z pulses after bits 4 and 6; MATCH_COUNT=2. Same stream with OVERLAP=0 -> only one pulse after bit 4; MATCH_COUNT=1.
- Default params, stream 0,1,1,0 with VALID=0 on two cycles inserted between bits -> still one match. Z is delayed only by the gaps.
- LOCK_ON_MATCH=1: X=0,1,1,0,0,1,1,0 -> LOCKED=1 after bit 4, one Z pulse, MATCH_COUNT=1. Then CLEAR with VALID=1 -> all outputs 0; the next 0,1,1,0 matches again.
- COUNT_WIDTH=2, OVERLAP=1, PATTERN=2'b11, X=1 for 6 cycles -> Z high on 5 consecutive cycles; MATCH_COUNT saturates at 3.
- Assert RESET asynchronously after X=0,1,1 -> outputs 0 with no clock edge; a following 0 does not match, and 0,1,1,0 afterwards does.
